// File: rtl/btb_table.sv
// Fully associative branch target buffer. Fetch looks it up combinationally;
// execute reports one resolved branch per cycle, which either trains the
// matching way or allocates a new one (lowest invalid way first, otherwise
// round-robin eviction).
module btb_table #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = 16,
  parameter int TAG_LSB = 5,
  parameter int CTR_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PC_W-1:0]              lookup_pc,
  output logic                         lookup_hit,
  output logic                         lookup_taken,
  output logic [PC_W-1:0]              lookup_target,
  input  logic                         upd_valid,
  input  logic [PC_W-1:0]              upd_pc,
  input  logic                         upd_taken,
  input  logic [PC_W-1:0]              upd_target,
  input  logic                         clear,
  output logic                         upd_hit,
  output logic                         mispredict,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy,
  output logic                         full
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);
  localparam int TAG_W = PC_W - TAG_LSB;

  localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [PC_W-1:0]    tgt_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic [IDX_W-1:0]   upd_idx, free_idx, victim_idx;
  logic               upd_msb, has_free;

  // Offset bits below TAG_LSB do not take part in the tag compare.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[TAG_LSB-1:0], upd_pc[TAG_LSB-1:0]};

  assign lk_tag = lookup_pc[PC_W-1:TAG_LSB];
  assign up_tag = upd_pc[PC_W-1:TAG_LSB];

  // Fetch-side lookup: tags are unique, so at most one way matches.
  always_comb begin
    lookup_hit    = 1'b0;
    lookup_taken  = 1'b0;
    lookup_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == lk_tag) begin
        lookup_hit    = 1'b1;
        lookup_taken  = ctr_q[i][CTR_W-1];
        lookup_target = tgt_q[i];
      end
    end
  end

  // Update-side match, and the lowest-index invalid way as allocation candidate.
  always_comb begin
    upd_hit  = 1'b0;
    upd_idx  = '0;
    upd_msb  = 1'b0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == up_tag) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
        upd_msb = ctr_q[i][CTR_W-1];
      end
    end
    // Scan downwards so the last assignment leaves the lowest invalid index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim_idx = has_free ? free_idx : rr_q;
  assign mispredict = upd_valid & upd_hit & (upd_taken ^ upd_msb);
  assign occupancy  = occ_q;
  assign full       = (occ_q == OCC_W'(ENTRIES));

  // Next-state: clear wins over any update; otherwise train on hit, allocate on miss.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    occ_d   = occ_q;
    if (clear) begin
      valid_d = '0;
      rr_d    = '0;
      occ_d   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_d[i] = '0;
        tgt_d[i] = '0;
        ctr_d[i] = '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          tgt_d[upd_idx] = upd_target;
          if (ctr_q[upd_idx] != '1) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
        end else begin
          if (ctr_q[upd_idx] != '0) ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else begin
        valid_d[victim_idx] = 1'b1;
        tag_d[victim_idx]   = up_tag;
        tgt_d[victim_idx]   = upd_target;
        ctr_d[victim_idx]   = upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        if (has_free) occ_d = occ_q + OCC_W'(1);
        else          rr_d  = rr_q + IDX_W'(1);  // power-of-two ENTRIES wraps naturally
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: tags/targets/counters are reset too, not just valid bits, because
      // the table must read all-zero after reset; this keeps it in flops, not RAM.
      valid_q <= '0;
      rr_q    <= '0;
      occ_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule
